// File: rtl/npu_seq_pkg.sv
// Shared types and sizing helpers for the systolic tile sequencer.
package npu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Step counter width: must hold the largest of the last feed step and the drain length.
    function automatic int cnt_w(input int n, input int drain_cyc);
        int m;
        m = ((2 * n - 1) > drain_cyc) ? (2 * n - 1) : drain_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/systolic_feed_sequencer_if.sv
// Operand-tile request and skewed feed bus between buffers, sequencer and PE array.
// SEQ_TILE_COUNT_EN adds the completed-tile counter output.
interface systolic_feed_sequencer_if #(
    parameter int N  = 2,
    parameter int DW = 8
);
    logic                           start;
    logic [N-1:0][N-1:0][DW-1:0]    A;
    logic [N-1:0][N-1:0][DW-1:0]    B;
    logic                           busy;
    logic                           acc_clr;
    logic [N-1:0][DW-1:0]           a_feed;
    logic [N-1:0][DW-1:0]           b_feed;
    logic [N-1:0]                   a_vld;
    logic [N-1:0]                   b_vld;
    logic                           done;
`ifdef SEQ_TILE_COUNT_EN
    logic [15:0]                    tile_cnt;
`endif

    modport master (
        output start, A, B,
        input  busy, acc_clr, a_feed, b_feed, a_vld, b_vld, done
`ifdef SEQ_TILE_COUNT_EN
        , input tile_cnt
`endif
    );

    modport slave (
        input  start, A, B,
        output busy, acc_clr, a_feed, b_feed, a_vld, b_vld, done
`ifdef SEQ_TILE_COUNT_EN
        , output tile_cnt
`endif
    );

endinterface

// File: rtl/systolic_feed_sequencer_skew_mux.sv
// Combinational diagonal skew: lane i presents element k=t-i of the latched tile while in window.
module systolic_skew_mux
    import npu_seq_pkg::*;
#(
    parameter int N        = 2,
    parameter int DW       = 8,
    parameter int CW       = 2,
    parameter bit COL_MODE = 1'b0
) (
    input  logic                        en,
    input  logic [CW-1:0]               t,
    input  logic [N-1:0][N-1:0][DW-1:0] tile,
    output logic [N-1:0][DW-1:0]        feed,
    output logic [N-1:0]                vld
);

    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int DIW = CW + 1;

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [DIW-1:0] diff_s;
        logic [IW-1:0]  k_s;
        logic           hit_s;
        logic [DW-1:0]  sel_s;

        // The extra MSB of diff_s flags t<g, i.e. the lane has not entered its window yet.
        assign diff_s = {1'b0, t} - DIW'(g);
        assign k_s    = diff_s[IW-1:0];
        assign hit_s  = en & ~diff_s[DIW-1] & (diff_s[CW-1:0] < CW'(N));

        if (COL_MODE) begin : g_col
            assign sel_s = tile[k_s][g];
        end else begin : g_row
            assign sel_s = tile[g][k_s];
        end

        assign feed[g] = hit_s ? sel_s : {DW{1'b0}};
        assign vld[g]  = hit_s;
    end

endmodule

// File: rtl/systolic_feed_sequencer.sv
// Tile sequencer for the NxN systolic array: latches a tile, feeds skewed streams, drains, signals done.
// Optional feature macro: SEQ_TILE_COUNT_EN (16-bit wrapping completed-tile counter).
module systolic_feed_sequencer
    import npu_seq_pkg::*;
#(
    parameter int N         = 2,
    parameter int DW        = 8,
    parameter int DRAIN_CYC = N
) (
    input  logic                    clk,
    input  logic                    rst,
    systolic_feed_sequencer_if.slave bus
);

    localparam int CW = cnt_w(N, DRAIN_CYC);
    localparam int NF = 2 * N - 1;

    seq_state_e                     state_r;
    seq_state_e                     state_nxt_s;
    logic [CW-1:0]                  t_r;
    logic [CW-1:0]                  t_nxt_s;
    logic                           cap_s;
    logic                           feed_en_s;
    logic [N-1:0][N-1:0][DW-1:0]    a_tile_r;
    logic [N-1:0][N-1:0][DW-1:0]    b_tile_r;

    // Next-state and step-counter decode; t is reused as the drain timer.
    always_comb begin
        state_nxt_s = state_r;
        t_nxt_s     = t_r;
        cap_s       = 1'b0;
        case (state_r)
            IDLE: begin
                t_nxt_s = {CW{1'b0}};
                if (bus.start) begin
                    state_nxt_s = FEED;
                    cap_s       = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FEED: begin
                if (t_r == CW'(NF - 1)) begin
                    state_nxt_s = DRAIN;
                    t_nxt_s     = {CW{1'b0}};
                end else begin
                    t_nxt_s     = t_r + CW'(1);
                end
            end
            DRAIN: begin
                if (t_r == CW'(DRAIN_CYC - 1)) begin
                    state_nxt_s = DONE;
                    t_nxt_s     = {CW{1'b0}};
                end else begin
                    t_nxt_s     = t_r + CW'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                t_nxt_s     = {CW{1'b0}};
            end
            default: begin
                state_nxt_s = IDLE;
                t_nxt_s     = {CW{1'b0}};
            end
        endcase
    end

    // State and step counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            t_r     <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            t_r     <= t_nxt_s;
        end
    end

    // Operand tiles are captured only on the accepted start, so later A/B changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_tile_r <= '0;
            b_tile_r <= '0;
        end else if (cap_s) begin
            a_tile_r <= bus.A;
            b_tile_r <= bus.B;
        end
    end

    assign feed_en_s = (state_r == FEED);

    systolic_skew_mux #(
        .N        (N),
        .DW       (DW),
        .CW       (CW),
        .COL_MODE (1'b0)
    ) u_a_skew (
        .en   (feed_en_s),
        .t    (t_r),
        .tile (a_tile_r),
        .feed (bus.a_feed),
        .vld  (bus.a_vld)
    );

    systolic_skew_mux #(
        .N        (N),
        .DW       (DW),
        .CW       (CW),
        .COL_MODE (1'b1)
    ) u_b_skew (
        .en   (feed_en_s),
        .t    (t_r),
        .tile (b_tile_r),
        .feed (bus.b_feed),
        .vld  (bus.b_vld)
    );

    assign bus.busy    = (state_r != IDLE);
    assign bus.acc_clr = feed_en_s && (t_r == {CW{1'b0}});
    assign bus.done    = (state_r == DONE);

`ifdef SEQ_TILE_COUNT_EN
    logic [15:0] tile_cnt_r;

    // Completed-tile counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_cnt_r <= 16'd0;
        end else if (state_r == DONE) begin
            tile_cnt_r <= tile_cnt_r + 16'd1;
        end
    end

    assign bus.tile_cnt = tile_cnt_r;
`endif

endmodule
